// File: rtl/ddr2_traffic_gen.sv
// Pattern-driven command generator for a DDR2 controller front end.
// Replays entries from a writable pattern memory, with optional wait cycles, write bursts and looping.
module ddr2_traffic_gen #(
    parameter  int DATA_W     = 16,
    parameter  int ADDR_W     = 25,
    parameter  int DEPTH      = 64,
    parameter  int CNT_W      = 8,
    parameter  int FIFO_LIMIT = 63,
    localparam int PAW        = $clog2(DEPTH),
    localparam int ENTRY_W    = CNT_W + 3 + 2 + 3 + ADDR_W + DATA_W + 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic               STOP,
    input  logic               LOOP,
    input  logic [PAW-1:0]     LAST,
    input  logic               PAT_WE,
    input  logic [PAW-1:0]     PAT_WADDR,
    input  logic [ENTRY_W-1:0] PAT_WDATA,
    input  logic               READY,
    input  logic               NOTFULL,
    input  logic [6:0]         FILLCOUNT,
    output logic [2:0]         CMD,
    output logic [1:0]         SZ,
    output logic [2:0]         OP,
    output logic [ADDR_W-1:0]  ADDR,
    output logic [DATA_W-1:0]  DIN,
    output logic               FETCHING,
    output logic               BUSY,
    output logic               DONE,
    output logic               ERR,
    output logic [PAW-1:0]     IDX,
    output logic [15:0]        ISSUED
);

    localparam int L_DATA = 1;
    localparam int L_ADDR = L_DATA + DATA_W;
    localparam int L_OP   = L_ADDR + ADDR_W;
    localparam int L_SZ   = L_OP + 3;
    localparam int L_CMD  = L_SZ + 2;
    localparam int L_WAIT = L_CMD + 3;
    localparam logic [6:0] FILL_MAX = 7'(FIFO_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_RDY, S_WAIT, S_ISSUE, S_BURST, S_DONE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [PAW-1:0]      r_idx, w_idx_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [5:0]          r_bcnt, w_bcnt_nxt;
    logic                r_err, w_err_nxt;
    logic [15:0]         r_issued, w_issued_nxt;
    logic [ENTRY_W-1:0]  r_mem [DEPTH];

    logic [ENTRY_W-1:0]  w_cur;
    logic [2:0]          w_cur_cmd;
    logic [1:0]          w_cur_sz;
    logic [5:0]          w_burst_len;
    logic [CNT_W-1:0]    w_adv_wait;
    logic                w_fill_ok, w_cmd_ok, w_adv, w_eoe;

    // NOTE: pattern memory is deliberately left out of reset; it is plain storage and keeps its contents.
    always_ff @(posedge CLK) begin
        if (PAT_WE) r_mem[PAT_WADDR] <= PAT_WDATA;
    end

    assign w_cur       = r_mem[r_idx];
    assign w_cur_cmd   = w_cur[L_CMD +: 3];
    assign w_cur_sz    = w_cur[L_SZ +: 2];
    assign w_burst_len = {1'b0, w_cur_sz, 3'b000} + 6'd8;
    assign w_fill_ok   = (FILLCOUNT <= FILL_MAX);

    always_comb begin
        w_cmd_ok = NOTFULL && w_fill_ok;
        case (w_cur_cmd)
            3'd0, 3'd7: w_cmd_ok = 1'b1;
            3'd1, 3'd3: w_cmd_ok = NOTFULL;
            default:    w_cmd_ok = NOTFULL && w_fill_ok;
        endcase
    end

    // NOTE: every combinational output gets a default before the case so no latch can be inferred.
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_cnt_nxt    = r_cnt;
        w_bcnt_nxt   = r_bcnt;
        w_err_nxt    = r_err;
        w_issued_nxt = r_issued;
        w_adv        = 1'b0;
        w_eoe        = 1'b0;
        w_adv_wait   = '0;
        CMD          = '0;
        SZ           = '0;
        OP           = '0;
        ADDR         = '0;
        DIN          = '0;
        FETCHING     = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                FETCHING = (r_state == S_DONE);
                if (START) begin
                    w_idx_nxt    = '0;
                    w_err_nxt    = 1'b0;
                    w_issued_nxt = '0;
                    if (READY) w_adv = 1'b1;
                    else       w_state_nxt = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: if (READY) w_adv = 1'b1;
            S_WAIT: begin
                if (r_cnt == CNT_W'(1)) w_state_nxt = S_ISSUE;
                else                    w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
            S_ISSUE: begin
                CMD      = w_cur_cmd;
                SZ       = w_cur_sz;
                OP       = w_cur[L_OP +: 3];
                ADDR     = w_cur[L_ADDR +: ADDR_W];
                DIN      = w_cur[L_DATA +: DATA_W];
                FETCHING = w_cur[0];
                if (w_cmd_ok) begin
                    w_issued_nxt = r_issued + 16'd1;
                    if (w_cur_cmd == 3'd4) begin
                        w_bcnt_nxt = w_burst_len;
                        // A burst whose first word would sit beyond LAST is an overrun at once.
                        if (r_idx == LAST) begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = S_DONE;
                        end else begin
                            w_idx_nxt   = r_idx + PAW'(1);
                            w_state_nxt = S_BURST;
                        end
                    end else begin
                        w_eoe = 1'b1;
                    end
                end
            end
            S_BURST: begin
                DIN      = w_cur[L_DATA +: DATA_W];
                FETCHING = w_cur[0];
                if (w_fill_ok) begin
                    w_bcnt_nxt = r_bcnt - 6'd1;
                    if (r_bcnt == 6'd1) begin
                        w_eoe = 1'b1;
                    end else if (r_idx == LAST) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt = r_idx + PAW'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_eoe) begin
            if (r_idx != LAST) begin
                w_idx_nxt = r_idx + PAW'(1);
                w_adv     = 1'b1;
            end else if (LOOP) begin
                w_idx_nxt = '0;
                w_adv     = 1'b1;
            end else begin
                w_state_nxt = S_DONE;
            end
        end

        // Advancing looks ahead at the entry being moved to so back-to-back issue needs no bubble.
        if (w_adv) begin
            w_adv_wait = r_mem[w_idx_nxt][L_WAIT +: CNT_W];
            w_cnt_nxt  = w_adv_wait;
            w_state_nxt = (w_adv_wait == '0) ? S_ISSUE : S_WAIT;
        end

        if (STOP) begin
            w_state_nxt  = S_IDLE;
            w_idx_nxt    = r_idx;
            w_cnt_nxt    = r_cnt;
            w_bcnt_nxt   = r_bcnt;
            w_err_nxt    = r_err;
            w_issued_nxt = r_issued;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_bcnt   <= '0;
            r_err    <= 1'b0;
            r_issued <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bcnt   <= w_bcnt_nxt;
            r_err    <= w_err_nxt;
            r_issued <= w_issued_nxt;
        end
    end

    assign BUSY   = (r_state == S_WAIT_RDY) || (r_state == S_WAIT) ||
                    (r_state == S_ISSUE) || (r_state == S_BURST);
    assign DONE   = (r_state == S_DONE);
    assign ERR    = r_err;
    assign IDX    = r_idx;
    assign ISSUED = r_issued;

endmodule

// File: tb/tb_ddr2_traffic_gen.sv
// Scoreboard bench for ddr2_traffic_gen: directed patterns, expected transactions queued by the stimulus,
// a monitor pops them as the DUT hands over commands and burst words.
module tb_ddr2_traffic_gen;

    localparam int PAW     = 6;
    localparam int ENTRY_W = 58;

    logic               CLK = 1'b0;
    logic               RESET, START, STOP, LOOP, PAT_WE, READY, NOTFULL;
    logic [PAW-1:0]     LAST, PAT_WADDR;
    logic [ENTRY_W-1:0] PAT_WDATA;
    logic [6:0]         FILLCOUNT;
    logic [2:0]         CMD, OP;
    logic [1:0]         SZ;
    logic [24:0]        ADDR;
    logic [15:0]        DIN, ISSUED;
    logic               FETCHING, BUSY, DONE, ERR;
    logic [PAW-1:0]     IDX;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [1:0]  sz;
        logic [2:0]  op;
        logic [24:0] addr;
        logic [15:0] din;
        logic        fetch;
        logic [7:0]  hold;
        logic [5:0]  idx;
        logic [15:0] issued;
    } txn_t;

    txn_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    ddr2_traffic_gen dut (
        .CLK(CLK), .RESET(RESET), .START(START), .STOP(STOP), .LOOP(LOOP), .LAST(LAST),
        .PAT_WE(PAT_WE), .PAT_WADDR(PAT_WADDR), .PAT_WDATA(PAT_WDATA),
        .READY(READY), .NOTFULL(NOTFULL), .FILLCOUNT(FILLCOUNT),
        .CMD(CMD), .SZ(SZ), .OP(OP), .ADDR(ADDR), .DIN(DIN), .FETCHING(FETCHING),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .IDX(IDX), .ISSUED(ISSUED)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [ENTRY_W-1:0] pack(input logic [7:0] w, input logic [2:0] c,
            input logic [1:0] s, input logic [2:0] o, input logic [24:0] a,
            input logic [15:0] d, input logic f);
        return {w, c, s, o, a, d, f};
    endfunction

    task automatic write_entry(input int i, input logic [ENTRY_W-1:0] e);
        PAT_WE    = 1'b1;
        PAT_WADDR = PAW'(i);
        PAT_WDATA = e;
        tick();
        PAT_WE    = 1'b0;
    endtask

    task automatic push(input logic [2:0] c, input logic [1:0] s, input logic [2:0] o,
            input logic [24:0] a, input logic [15:0] d, input logic f,
            input int h, input int i, input int iss);
        txn_t t;
        t = '{cmd: c, sz: s, op: o, addr: a, din: d, fetch: f,
              hold: 8'(h), idx: 6'(i), issued: 16'(iss)};
        exp_q.push_back(t);
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (DONE !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({name, "_reached_done"}, 32'(DONE), 32'd1);
    endtask

    // Monitor: a command or burst word is handed over when the controller-side rules accept it.
    initial begin
        int   hold = 0;
        logic cons;
        txn_t act, exp;
        forever begin
            @(negedge CLK);
            cons = 1'b0;
            if (RESET !== 1'b1 || STOP === 1'b1) begin
                hold = 0;
            end else if (CMD != 3'd0 || (BUSY === 1'b1 && DIN != 16'd0)) begin
                hold++;
                if (CMD == 3'd7)                     cons = 1'b1;
                else if (CMD == 3'd1 || CMD == 3'd3) cons = NOTFULL;
                else if (CMD != 3'd0)                cons = NOTFULL && (FILLCOUNT <= 7'd63);
                else                                 cons = (FILLCOUNT <= 7'd63);
            end
            if (cons) begin
                act = '{cmd: CMD, sz: SZ, op: OP, addr: ADDR, din: DIN, fetch: FETCHING,
                        hold: 8'(hold), idx: IDX, issued: ISSUED};
                hold = 0;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL txn_unexpected: got cmd=%0d din=%h idx=%0d with nothing queued",
                             act.cmd, act.din, act.idx);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        n_fail++;
                        $display("FAIL txn: got cmd=%0d sz=%0d op=%0d addr=%h din=%h f=%0d hold=%0d idx=%0d iss=%0d, expected cmd=%0d sz=%0d op=%0d addr=%h din=%h f=%0d hold=%0d idx=%0d iss=%0d",
                                 act.cmd, act.sz, act.op, act.addr, act.din, act.fetch, act.hold, act.idx, act.issued,
                                 exp.cmd, exp.sz, exp.op, exp.addr, exp.din, exp.fetch, exp.hold, exp.idx, exp.issued);
                    end
                end
            end
        end
    end

    initial begin
        RESET = 1'b0; START = 1'b0; STOP = 1'b0; LOOP = 1'b0; LAST = '0;
        PAT_WE = 1'b0; PAT_WADDR = '0; PAT_WDATA = '0;
        READY = 1'b1; NOTFULL = 1'b1; FILLCOUNT = 7'd0;
        tick();
        tick();
        check("rst_busy", 32'(BUSY), 0);
        check("rst_done", 32'(DONE), 0);
        check("rst_err", 32'(ERR), 0);
        check("rst_idx", 32'(IDX), 0);
        check("rst_issued", 32'(ISSUED), 0);
        check("rst_cmd_din", {13'd0, CMD, DIN}, 0);
        RESET = 1'b1;

        // Single SCW
        write_entry(0, pack(8'd0, 3'd2, 2'd0, 3'd0, 25'h008F07A, 16'hFACE, 1'b0));
        LAST = 6'd0;
        push(3'd2, 2'd0, 3'd0, 25'h008F07A, 16'hFACE, 1'b0, 1, 0, 0);
        pulse_start();
        check("scw_cmd", 32'(CMD), 2);
        wait_done("scw", 10);
        check("scw_fetching", 32'(FETCHING), 1);
        check("scw_issued", 32'(ISSUED), 1);
        check("scw_busy", 32'(BUSY), 0);

        // Wait for READY, then WAIT=3
        write_entry(0, pack(8'd3, 3'd1, 2'd2, 3'd5, 25'h0000123, 16'h0011, 1'b1));
        READY = 1'b0;
        push(3'd1, 2'd2, 3'd5, 25'h0000123, 16'h0011, 1'b1, 1, 0, 0);
        pulse_start();
        repeat (10) tick();
        check("wrdy_busy", 32'(BUSY), 1);
        check("wrdy_cmd", 32'(CMD), 0);
        READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_nop", {28'd0, BUSY, CMD}, {28'd0, 1'b1, 3'd0});
        end
        tick();
        check("wait_then_cmd", 32'(CMD), 1);
        wait_done("wait", 10);

        // Backpressure: SCW stalled by FILLCOUNT, SCR stalled by NOTFULL only
        write_entry(0, pack(8'd0, 3'd2, 2'd1, 3'd3, 25'h00000A0, 16'h5A5A, 1'b0));
        write_entry(1, pack(8'd0, 3'd1, 2'd0, 3'd0, 25'h00000B0, 16'h0000, 1'b0));
        LAST = 6'd1;
        push(3'd2, 2'd1, 3'd3, 25'h00000A0, 16'h5A5A, 1'b0, 6, 0, 0);
        push(3'd1, 2'd0, 3'd0, 25'h00000B0, 16'h0000, 1'b0, 5, 1, 1);
        FILLCOUNT = 7'd64;
        pulse_start();
        repeat (5) tick();
        FILLCOUNT = 7'd0;
        tick();
        check("b2b_scr", {26'd0, CMD, IDX}, {26'd0, 3'd1, 6'd1});
        NOTFULL = 1'b0;
        FILLCOUNT = 7'd64;
        repeat (4) tick();
        NOTFULL = 1'b1;
        wait_done("bp", 10);
        FILLCOUNT = 7'd0;

        // BLW SZ=0 with 8 data words, FILLCOUNT alternating
        write_entry(0, pack(8'd0, 3'd4, 2'd0, 3'd0, 25'h0000100, 16'h0000, 1'b0));
        for (int i = 1; i <= 8; i++)
            write_entry(i, pack(8'd5, 3'd3, 2'd3, 3'd7, 25'h0001234, 16'(i), 1'(i % 2)));
        LAST = 6'd8;
        push(3'd4, 2'd0, 3'd0, 25'h0000100, 16'h0000, 1'b0, 1, 0, 0);
        for (int i = 1; i <= 8; i++)
            push(3'd0, 2'd0, 3'd0, 25'h0, 16'(i), 1'(i % 2), 2, i, 1);
        pulse_start();
        for (int i = 1; i <= 8; i++) begin
            tick();
            FILLCOUNT = 7'd64;
            tick();
            FILLCOUNT = 7'd0;
        end
        wait_done("blw", 5);
        check("blw_idx", 32'(IDX), 8);
        check("blw_issued", 32'(ISSUED), 1);
        check("blw_err", 32'(ERR), 0);

        // LOOP over two NOPs, then STOP
        write_entry(0, pack(8'd0, 3'd7, 2'd0, 3'd0, 25'h0, 16'h0, 1'b0));
        write_entry(1, pack(8'd0, 3'd7, 2'd0, 3'd0, 25'h0, 16'h0, 1'b0));
        LAST = 6'd1;
        LOOP = 1'b1;
        for (int i = 0; i < 4; i++) push(3'd7, 2'd0, 3'd0, 25'h0, 16'h0, 1'b0, 1, i % 2, i);
        pulse_start();
        repeat (4) tick();
        STOP = 1'b1;
        tick();
        check("stop_busy", 32'(BUSY), 0);
        check("stop_idx", 32'(IDX), 0);
        check("stop_issued", 32'(ISSUED), 4);
        check("stop_cmd", 32'(CMD), 0);
        START = 1'b1;
        tick();
        check("stop_wins_busy", 32'(BUSY), 0);
        check("stop_wins_issued", 32'(ISSUED), 4);
        START = 1'b0;
        STOP = 1'b0;
        LOOP = 1'b0;

        // Burst overrun past LAST
        write_entry(0, pack(8'd2, 3'd3, 2'd0, 3'd1, 25'h1FFFFFF, 16'hFFFF, 1'b1));
        write_entry(1, pack(8'd0, 3'd7, 2'd0, 3'd0, 25'h0, 16'h0, 1'b0));
        write_entry(2, pack(8'd0, 3'd4, 2'd1, 3'd0, 25'h0000200, 16'h0, 1'b0));
        write_entry(3, pack(8'd9, 3'd2, 2'd0, 3'd0, 25'h0, 16'h0033, 1'b0));
        write_entry(4, pack(8'd9, 3'd2, 2'd0, 3'd0, 25'h0, 16'h0044, 1'b1));
        write_entry(5, pack(8'd9, 3'd2, 2'd0, 3'd0, 25'h0, 16'h0055, 1'b0));
        LAST = 6'd5;
        push(3'd3, 2'd0, 3'd1, 25'h1FFFFFF, 16'hFFFF, 1'b1, 1, 0, 0);
        push(3'd7, 2'd0, 3'd0, 25'h0, 16'h0, 1'b0, 1, 1, 1);
        push(3'd4, 2'd1, 3'd0, 25'h0000200, 16'h0, 1'b0, 1, 2, 2);
        push(3'd0, 2'd0, 3'd0, 25'h0, 16'h0033, 1'b0, 1, 3, 3);
        push(3'd0, 2'd0, 3'd0, 25'h0, 16'h0044, 1'b1, 1, 4, 3);
        push(3'd0, 2'd0, 3'd0, 25'h0, 16'h0055, 1'b0, 1, 5, 3);
        pulse_start();
        wait_done("ovr", 40);
        check("ovr_err", 32'(ERR), 1);
        check("ovr_idx", 32'(IDX), 5);
        check("ovr_issued", 32'(ISSUED), 3);

        // Restart clears ERR; reset lands mid-burst
        push(3'd3, 2'd0, 3'd1, 25'h1FFFFFF, 16'hFFFF, 1'b1, 1, 0, 0);
        push(3'd7, 2'd0, 3'd0, 25'h0, 16'h0, 1'b0, 1, 1, 1);
        push(3'd4, 2'd1, 3'd0, 25'h0000200, 16'h0, 1'b0, 1, 2, 2);
        push(3'd0, 2'd0, 3'd0, 25'h0, 16'h0033, 1'b0, 1, 3, 3);
        pulse_start();
        check("restart_err", 32'(ERR), 0);
        check("restart_issued", 32'(ISSUED), 0);
        repeat (6) tick();
        check("midburst", {9'd0, BUSY, FETCHING, IDX, DIN}, {9'd0, 1'b1, 1'b1, 6'd4, 16'h0044});
        RESET = 1'b0;
        tick();
        check("rst_mid_ctrl", {9'd0, CMD, SZ, OP, FETCHING, BUSY, DONE, ERR, IDX},
              32'd0);
        check("rst_mid_addr_din", {7'd0, ADDR} | {16'd0, DIN}, 32'd0);
        check("rst_mid_issued", 32'(ISSUED), 0);
        RESET = 1'b1;

        // Pattern memory survives reset
        LAST = 6'd0;
        push(3'd3, 2'd0, 3'd1, 25'h1FFFFFF, 16'hFFFF, 1'b1, 1, 0, 0);
        pulse_start();
        wait_done("after_rst", 10);

        repeat (3) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr2_traffic_gen.md
DDR2_TRAFFIC_GEN -- requirements
Module: ddr2_traffic_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 16, DIN width.
- ADDR_W, 25, ADDR width.
- DEPTH, 64, pattern-memory entries; PAW = clog2(DEPTH).
- CNT_W, 8, wait-field width.
- FIFO_LIMIT, 63, largest FILLCOUNT value at which the data FIFO still accepts a word.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK, in, 1, system clock.
- RESET, in, 1, synchronous active-low reset.
- START, in, 1, begin pattern at index 0.
- STOP, in, 1, abort to IDLE.
- LOOP, in, 1, wrap at end of pattern.
- LAST, in, PAW, index of final entry.
- PAT_WE, in, 1, pattern write enable.
- PAT_WADDR, in, PAW, pattern write index.
- PAT_WDATA, in, ENTRY_W, entry to write.
- READY, in, 1, controller initialised.
- NOTFULL, in, 1, command FIFO has space.
- FILLCOUNT, in, 7, data FIFO fill level.
- CMD, out, 3, command to controller.
- SZ, out, 2, size to controller.
- OP, out, 3, op to controller.
- ADDR, out, ADDR_W, address to controller.
- DIN, out, DATA_W, data to controller.
- FETCHING, out, 1, fetching flag to controller.
- BUSY, out, 1, pattern running.
- DONE, out, 1, pattern finished.
- ERR, out, 1, burst overrun.
- IDX, out, PAW, current entry index.
- ISSUED, out, 16, count of consumed commands.

REQ-003 Entry layout SHALL be, MSB to LSB: WAIT[CNT_W], CMD[3], SZ[2], OP[3], ADDR[ADDR_W], DATA[DATA_W], FETCHING[1]. ENTRY_W is the sum of these field widths.

Function
REQ-004 Pattern memory SHALL be DEPTH x ENTRY_W, written on a CLK edge when PAT_WE=1 (writes are allowed in any state) and read combinationally at IDX. A same-cycle read of an address being written SHALL return the old entry.

REQ-005 The FSM SHALL have exactly these states: IDLE, WAIT_RDY, WAIT, ISSUE, BURST, DONE.

REQ-006 In IDLE, WAIT_RDY and WAIT the outputs SHALL be CMD=0, SZ=0, OP=0, ADDR=0, DIN=0, FETCHING=0. In DONE the outputs SHALL be the same, except FETCHING=1.

REQ-007 START in IDLE or DONE SHALL set IDX=0, clear ERR and clear ISSUED.
- If READY=1, the FSM SHALL advance immediately.
- If READY=0, the FSM SHALL enter WAIT_RDY and advance on the first cycle with READY=1.
- START SHALL be ignored in all other states.

REQ-008 Advance SHALL evaluate entry[IDX]:
- WAIT=0: enter ISSUE on the next edge.
- WAIT=W>0: enter WAIT, load the counter with W, and decrement it each cycle. Enter ISSUE after exactly W cycles in WAIT.

REQ-009 In ISSUE, CMD/SZ/OP/ADDR/DIN/FETCHING SHALL equal the fields of entry[IDX], held until the command is consumed.

REQ-010 Consumption rules:
- CMD 0 or 7 (NOP): consumed in the same cycle.
- CMD 1 or 3: consumed when NOTFULL=1.
- CMD 2, 4, 5, 6: consumed when NOTFULL=1 and FILLCOUNT<=FIFO_LIMIT.

REQ-011 On consume:
- ISSUED SHALL increment (wrapping at 2^16).
- If CMD=4, the FSM SHALL load the burst counter with 8*(SZ+1) (6 bits, 8..32), set IDX+1 and enter BURST.
- Otherwise it SHALL take the end-of-entry action (REQ-013).

REQ-012 In BURST:
- Outputs SHALL be CMD=0, SZ=0, OP=0, ADDR=0, DIN=entry[IDX].DATA, FETCHING=entry[IDX].FETCHING. WAIT/CMD/SZ/OP/ADDR of burst entries SHALL be ignored.
- A word is consumed each cycle FILLCOUNT<=FIFO_LIMIT; on consume the burst counter SHALL decrement.
- On consuming the last word (counter=1) the FSM SHALL take the end-of-entry action.
- On consuming a non-final word the FSM SHALL set IDX+1.
- Burst words SHALL NOT increment ISSUED.

REQ-013 End-of-entry action:
- If IDX=LAST and LOOP=1: set IDX=0 and advance.
- If IDX=LAST and LOOP=0: enter DONE.
- Otherwise: set IDX+1 and advance.
- When the next entry has WAIT=0, back-to-back ISSUE SHALL occur with no idle cycle.

REQ-014 If a burst needs a word beyond LAST, the FSM SHALL set ERR=1 (sticky until START or reset) and enter DONE on the next edge. The overrun word SHALL NOT be presented.

REQ-015 STOP in any state SHALL return the FSM to IDLE on the next edge, with outputs per REQ-006. IDX, ISSUED and ERR SHALL be held.

REQ-016 Status flags:
- BUSY SHALL be 1 in WAIT_RDY, WAIT, ISSUE and BURST.
- DONE SHALL be 1 only in the DONE state.
- STOP and START asserted together: STOP SHALL win.

Reset
REQ-017 When RESET=0 at a CLK edge, the block SHALL enter IDLE with all outputs 0 (IDX=0, ISSUED=0, ERR=0, DONE=0, BUSY=0), including mid-WAIT or mid-BURST. Pattern memory contents SHALL NOT be reset.

Verification
REQ-018 A bench SHALL cover these directed scenarios:
- Single SCW {WAIT=0, CMD=2, ADDR=0x008F07A, DATA=0xFACE}, LAST=0, NOTFULL=1, FILLCOUNT=0, START with READY=1 -> CMD=2 with that ADDR/DIN for 1 cycle, then DONE=1, FETCHING=1, ISSUED=1.
- Entry {WAIT=3, CMD=1}, READY held 0 for 10 cycles after START -> BUSY=1 while waiting; after READY rises, 3 NOP cycles, then CMD=1.
- Backpressure: SCW with FILLCOUNT=64 for 5 cycles -> CMD=2 held 6 cycles. SCR with NOTFULL=0 for 4 cycles -> CMD=1 held 5 cycles, and FILLCOUNT=64 SHALL NOT stall it.
- BLW SZ=0 at index 0 followed by 8 data entries 0x0001..0x0008, FILLCOUNT alternating 64/0 -> 8 DIN words presented in order, each for 2 cycles. Afterwards IDX=8 and ISSUED=1.
- LOOP=1, LAST=1, two NOP entries -> IDX sequence 0,1,0,1 with ISSUED=1,2,3,4. STOP -> IDLE next cycle, IDX held.
- BLW SZ=1 at index 2 with LAST=5 -> ERR=1 and DONE=1 after 3 burst words. A separate run with RESET=0 mid-burst -> all outputs 0 on the next edge.
